// File: rtl/game_pkg.sv
// Shared state encoding and match defaults for the multi-round Hangman status block.
package game_pkg;

    localparam int STATE_W        = 3;
    localparam int DEF_MAX_MISSES = 6;
    localparam int DEF_NUM_ROUNDS = 3;

    typedef enum logic [STATE_W-1:0] {
        START     = 3'd0,
        INGAME    = 3'd1,
        WINGAME   = 3'd2,
        LOSTGAME  = 3'd3,
        PAUSED    = 3'd4,
        MATCHOVER = 3'd5
    } state_t;

endpackage

// File: rtl/guess_timer.sv
// Per-guess down-counter: reload has priority over decrement; expires when the count sits at 1.
module guess_timer #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TMR_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    output logic [TMR_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (TIMEOUT_CYCLES != 0) begin
            if (load) begin
                count <= TMR_W'(TIMEOUT_CYCLES);
            end else if (en && count != '0) begin
                count <= count - TMR_W'(1);
            end
        end
    end

    // A disabled timer stays at zero and never expires.
    assign expired = (TIMEOUT_CYCLES != 0) && (count == TMR_W'(1));

endmodule

// File: rtl/game_status_multi.sv
// Best-of-N Hangman match controller: round FSM, miss/reveal counting, pause and per-guess timeout.
module game_status_multi
    import game_pkg::*;
#(
    parameter int MAX_MISSES     = DEF_MAX_MISSES,
    parameter int LEN_W          = 4,
    parameter int NUM_ROUNDS     = DEF_NUM_ROUNDS,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TMR_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_game,
    input  logic               pause_toggle,
    input  logic               guess_valid,
    input  logic               guess_hit,
    input  logic [LEN_W-1:0]   hit_count,
    input  logic [LEN_W-1:0]   word_len,
    output logic [STATE_W-1:0] current_state,
    output logic [3:0]         miss_count,
    output logic [LEN_W-1:0]   revealed_count,
    output logic [TMR_W-1:0]   guess_timer,
    output logic [3:0]         rounds_won,
    output logic [3:0]         rounds_played
);

    state_t           state, state_n;
    logic [3:0]       miss_n, won_n, played_n;
    logic [LEN_W-1:0] rev_n, wlen, wlen_n;
    logic             tmr_load, tmr_en, tmr_expired;
    logic             guess_ev, miss_ev;

    function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a,
                                                 input logic [LEN_W-1:0] b,
                                                 input logic [LEN_W-1:0] lim);
        logic [LEN_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) return lim;
        return sum[LEN_W-1:0];
    endfunction

    guess_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMR_W         (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .en     (tmr_en),
        .count  (guess_timer),
        .expired(tmr_expired)
    );

    always_comb begin
        state_n  = state;
        miss_n   = miss_count;
        rev_n    = revealed_count;
        wlen_n   = wlen;
        won_n    = rounds_won;
        played_n = rounds_played;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        guess_ev = 1'b0;
        miss_ev  = 1'b0;
        case (state)
            START: begin
                if (start_game) begin
                    state_n  = INGAME;
                    wlen_n   = word_len;
                    miss_n   = 4'd0;
                    rev_n    = '0;
                    tmr_load = 1'b1;
                end
            end
            INGAME: begin
                // An expiring timer counts as a miss only when no real guess arrives that cycle.
                guess_ev = guess_valid || tmr_expired;
                miss_ev  = guess_valid ? !guess_hit : tmr_expired;
                tmr_load = guess_ev;
                if (guess_valid && guess_hit) rev_n = sat_add(revealed_count, hit_count, wlen);
                if (miss_ev) miss_n = miss_count + 4'd1;
                if (rev_n >= wlen) begin
                    state_n  = WINGAME;
                    won_n    = rounds_won + 4'd1;
                    played_n = rounds_played + 4'd1;
                end else if (miss_n == 4'(MAX_MISSES)) begin
                    state_n  = LOSTGAME;
                    played_n = rounds_played + 4'd1;
                end else begin
                    tmr_en = 1'b1;
                    if (pause_toggle && !guess_ev) state_n = PAUSED;
                end
            end
            PAUSED: begin
                if (start_game)        state_n = START;
                else if (pause_toggle) state_n = INGAME;
            end
            WINGAME, LOSTGAME: begin
                if (start_game) state_n = (rounds_played == 4'(NUM_ROUNDS)) ? MATCHOVER : START;
            end
            MATCHOVER: begin
                if (start_game) begin
                    state_n  = START;
                    won_n    = 4'd0;
                    played_n = 4'd0;
                end
            end
            default: state_n = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= START;
            miss_count     <= 4'd0;
            revealed_count <= '0;
            wlen           <= '0;
            rounds_won     <= 4'd0;
            rounds_played  <= 4'd0;
        end else begin
            state          <= state_n;
            miss_count     <= miss_n;
            revealed_count <= rev_n;
            wlen           <= wlen_n;
            rounds_won     <= won_n;
            rounds_played  <= played_n;
        end
    end

    assign current_state = state;

endmodule

// File: tb/tb_game_status_multi.sv
// Directed bench for game_status_multi: a full 3-round match, timeout with pause, and abort paths.
module tb_game_status_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_game, pause_toggle, guess_valid, guess_hit;
    logic [3:0]  hit_count, word_len;
    logic [2:0]  current_state;
    logic [3:0]  miss_count, revealed_count, rounds_won, rounds_played;
    logic [31:0] guess_timer;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    game_status_multi #(
        .MAX_MISSES    (6),
        .LEN_W         (4),
        .NUM_ROUNDS    (3),
        .TIMEOUT_CYCLES(10),
        .TMR_W         (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_game    (start_game),
        .pause_toggle  (pause_toggle),
        .guess_valid   (guess_valid),
        .guess_hit     (guess_hit),
        .hit_count     (hit_count),
        .word_len      (word_len),
        .current_state (current_state),
        .miss_count    (miss_count),
        .revealed_count(revealed_count),
        .guess_timer   (guess_timer),
        .rounds_won    (rounds_won),
        .rounds_played (rounds_played)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_game = 1'b1; tick(); start_game = 1'b0;
    endtask

    task automatic guess(input logic hit, input logic [3:0] cnt);
        guess_valid = 1'b1; guess_hit = hit; hit_count = cnt;
        tick();
        guess_valid = 1'b0; guess_hit = 1'b0; hit_count = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start_game = 0; pause_toggle = 0; guess_valid = 0; guess_hit = 0;
        hit_count = 0; word_len = 4'd5;
        tick(2);
        vectors++; if (current_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", current_state); end
        vectors++; if (miss_count !== 4'd0 || revealed_count !== 4'd0) begin errors++; $display("FAIL rst_counts got miss=%0d rev=%0d want 0/0", miss_count, revealed_count); end
        vectors++; if (guess_timer !== 32'd0 || rounds_won !== 4'd0 || rounds_played !== 4'd0) begin errors++; $display("FAIL rst_match got tmr=%0d won=%0d played=%0d want 0", guess_timer, rounds_won, rounds_played); end
        reset = 1'b1; tick();
        vectors++; if (current_state !== 3'd0) begin errors++; $display("FAIL idle_state got %0d want 0", current_state); end
        pulse_start();
        vectors++; if (current_state !== 3'd1) begin errors++; $display("FAIL start_state got %0d want 1", current_state); end
        vectors++; if (miss_count !== 4'd0 || revealed_count !== 4'd0) begin errors++; $display("FAIL start_counts got miss=%0d rev=%0d want 0/0", miss_count, revealed_count); end
        vectors++; if (guess_timer !== 32'd10) begin errors++; $display("FAIL start_timer got %0d want 10", guess_timer); end
    endtask

    task automatic test_win();
        guess(1'b1, 4'd2);
        vectors++; if (revealed_count !== 4'd2 || current_state !== 3'd1) begin errors++; $display("FAIL win_hit1 got rev=%0d st=%0d want 2/1", revealed_count, current_state); end
        guess(1'b1, 4'd1);
        vectors++; if (revealed_count !== 4'd3) begin errors++; $display("FAIL win_hit2 got rev=%0d want 3", revealed_count); end
        guess(1'b1, 4'd2);
        vectors++; if (current_state !== 3'd2 || revealed_count !== 4'd5) begin errors++; $display("FAIL win_state got st=%0d rev=%0d want 2/5", current_state, revealed_count); end
        vectors++; if (rounds_won !== 4'd1 || rounds_played !== 4'd1) begin errors++; $display("FAIL win_rounds got won=%0d played=%0d want 1/1", rounds_won, rounds_played); end
        guess(1'b0, 4'd0);
        vectors++; if (current_state !== 3'd2 || miss_count !== 4'd0) begin errors++; $display("FAIL win_hold got st=%0d miss=%0d want 2/0", current_state, miss_count); end
    endtask

    task automatic test_loss();
        pulse_start();
        vectors++; if (current_state !== 3'd0) begin errors++; $display("FAIL next_round got %0d want 0", current_state); end
        pulse_start();
        vectors++; if (current_state !== 3'd1 || revealed_count !== 4'd0) begin errors++; $display("FAIL loss_enter got st=%0d rev=%0d want 1/0", current_state, revealed_count); end
        pause_toggle = 1'b1; guess(1'b0, 4'd0); pause_toggle = 1'b0;
        vectors++; if (current_state !== 3'd1 || miss_count !== 4'd1) begin errors++; $display("FAIL pause_vs_guess got st=%0d miss=%0d want 1/1", current_state, miss_count); end
        for (int i = 0; i < 4; i++) guess(1'b0, 4'd0);
        vectors++; if (current_state !== 3'd1 || miss_count !== 4'd5) begin errors++; $display("FAIL loss_miss5 got st=%0d miss=%0d want 1/5", current_state, miss_count); end
        guess(1'b0, 4'd0);
        vectors++; if (current_state !== 3'd3 || miss_count !== 4'd6) begin errors++; $display("FAIL loss_state got st=%0d miss=%0d want 3/6", current_state, miss_count); end
        vectors++; if (rounds_won !== 4'd1 || rounds_played !== 4'd2) begin errors++; $display("FAIL loss_rounds got won=%0d played=%0d want 1/2", rounds_won, rounds_played); end
    endtask

    task automatic test_overshoot();
        pulse_start(); pulse_start();
        guess(1'b1, 4'd4);
        vectors++; if (revealed_count !== 4'd4 || current_state !== 3'd1) begin errors++; $display("FAIL over_hit1 got rev=%0d st=%0d want 4/1", revealed_count, current_state); end
        guess(1'b1, 4'd3);
        vectors++; if (revealed_count !== 4'd5 || current_state !== 3'd2) begin errors++; $display("FAIL over_sat got rev=%0d st=%0d want 5/2", revealed_count, current_state); end
        vectors++; if (rounds_won !== 4'd2 || rounds_played !== 4'd3) begin errors++; $display("FAIL over_rounds got won=%0d played=%0d want 2/3", rounds_won, rounds_played); end
    endtask

    task automatic test_match();
        pulse_start();
        vectors++; if (current_state !== 3'd5 || rounds_won !== 4'd2) begin errors++; $display("FAIL match_over got st=%0d won=%0d want 5/2", current_state, rounds_won); end
        tick(3);
        vectors++; if (current_state !== 3'd5) begin errors++; $display("FAIL match_hold got %0d want 5", current_state); end
        pulse_start();
        vectors++; if (current_state !== 3'd0 || rounds_won !== 4'd0 || rounds_played !== 4'd0) begin errors++; $display("FAIL match_clear got st=%0d won=%0d played=%0d want 0/0/0", current_state, rounds_won, rounds_played); end
    endtask

    task automatic test_timeout();
        pulse_start();
        tick(9);
        vectors++; if (guess_timer !== 32'd1 || miss_count !== 4'd0) begin errors++; $display("FAIL tmo_pre got tmr=%0d miss=%0d want 1/0", guess_timer, miss_count); end
        tick();
        vectors++; if (guess_timer !== 32'd10 || miss_count !== 4'd1) begin errors++; $display("FAIL tmo_miss got tmr=%0d miss=%0d want 10/1", guess_timer, miss_count); end
        tick(3);
        pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
        vectors++; if (current_state !== 3'd4 || guess_timer !== 32'd6) begin errors++; $display("FAIL pause_enter got st=%0d tmr=%0d want 4/6", current_state, guess_timer); end
        tick(2); guess(1'b0, 4'd0); tick(2);
        vectors++; if (guess_timer !== 32'd6 || miss_count !== 4'd1) begin errors++; $display("FAIL pause_freeze got tmr=%0d miss=%0d want 6/1", guess_timer, miss_count); end
        pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
        vectors++; if (current_state !== 3'd1 || guess_timer !== 32'd6) begin errors++; $display("FAIL resume got st=%0d tmr=%0d want 1/6", current_state, guess_timer); end
        tick(5);
        vectors++; if (miss_count !== 4'd1 || guess_timer !== 32'd1) begin errors++; $display("FAIL resume_pre got miss=%0d tmr=%0d want 1/1", miss_count, guess_timer); end
        tick();
        vectors++; if (miss_count !== 4'd2 || guess_timer !== 32'd10) begin errors++; $display("FAIL resume_miss got miss=%0d tmr=%0d want 2/10", miss_count, guess_timer); end
    endtask

    task automatic test_abort();
        pause_toggle = 1'b1; tick(); pause_toggle = 1'b0;
        pulse_start();
        vectors++; if (current_state !== 3'd0 || rounds_played !== 4'd0) begin errors++; $display("FAIL pause_abandon got st=%0d played=%0d want 0/0", current_state, rounds_played); end
        pulse_start();
        guess(1'b1, 4'd3);
        vectors++; if (revealed_count !== 4'd3 || miss_count !== 4'd0) begin errors++; $display("FAIL abort_setup got rev=%0d miss=%0d want 3/0", revealed_count, miss_count); end
        reset = 1'b0; tick();
        vectors++; if (current_state !== 3'd0 || revealed_count !== 4'd0 || guess_timer !== 32'd0) begin errors++; $display("FAIL abort_reset got st=%0d rev=%0d tmr=%0d want 0/0/0", current_state, revealed_count, guess_timer); end
        reset = 1'b1; tick();
        vectors++; if (current_state !== 3'd0 || miss_count !== 4'd0) begin errors++; $display("FAIL abort_idle got st=%0d miss=%0d want 0/0", current_state, miss_count); end
    endtask

    initial begin
        test_reset();
        test_win();
        test_loss();
        test_overshoot();
        test_match();
        test_timeout();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/game_status_multi.md
Name: game_status_multi

Overview:
- Parametrised successor to the single-round game status FSM.
- Runs a best-of-N Hangman match. Detects win/loss internally from guess events instead of taking win/lost flags.
- Counts misses against a configurable limit and enforces an optional per-guess timeout.
- Supports pause. Sits between the guess checker (upstream) and the display/VGA drivers (downstream).

Parameters:
MAX_MISSES, 6, wrong guesses allowed per round; the MAX_MISSES-th miss loses the round (1..15)
LEN_W, 4, width of word length and revealed-letter counts
NUM_ROUNDS, 3, rounds per match (1..15)
TIMEOUT_CYCLES, 0, cycles allowed per guess before an automatic miss; 0 disables the timer
TMR_W, 32, timer width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start_game  in  1  single-cycle pulse: start, advance to next round, or restart
pause_toggle  in  1  single-cycle pulse; toggles INGAME<->PAUSED
guess_valid  in  1  single-cycle guess strobe
guess_hit  in  1  qualified by guess_valid; 1 = letter present in word
hit_count  in  LEN_W  qualified by guess_valid&guess_hit; number of newly revealed positions
word_len  in  LEN_W  current word length; sampled on entry to INGAME
current_state  out  3  START=0, INGAME=1, WINGAME=2, LOSTGAME=3, PAUSED=4, MATCHOVER=5
miss_count  out  4  misses this round
revealed_count  out  LEN_W  letters revealed this round
guess_timer  out  TMR_W  cycles remaining for the current guess; 0 when the timer is disabled
rounds_won  out  4  rounds won in this match
rounds_played  out  4  rounds completed in this match

Behaviour:
- Registered outputs only.
- All outputs are 0 and state is START while reset==0. Reset mid-game aborts immediately to START; no partial state is kept.
- START: on start_game, enter INGAME next cycle.
  - Latch word_len; clear miss_count and revealed_count.
  - Load guess_timer with TIMEOUT_CYCLES.
  - rounds_won and rounds_played are unchanged here; they clear only on reset or on leaving MATCHOVER.
- INGAME, evaluated each cycle in this priority:
  1. Guess or timeout event. A valid hit adds hit_count to revealed_count, saturating at the latched word_len. A valid miss, or guess_timer reaching 1 with no valid guess that cycle, increments miss_count. Either event reloads guess_timer.
  2. Win: post-update revealed_count >= latched word_len → WINGAME; rounds_won+1 and rounds_played+1 in the same cycle.
  3. Loss: post-update miss_count == MAX_MISSES → LOSTGAME; rounds_played+1.
  4. Otherwise guess_timer decrements by 1 when TIMEOUT_CYCLES != 0.
  5. pause_toggle with no guess event that cycle → PAUSED.
- A guess arriving in the same cycle as pause_toggle takes priority; pause is ignored.
- Both win and loss conditions in the same cycle cannot occur, since a single event is either a hit or a miss.
- PAUSED:
  - guess_timer frozen; guess_valid ignored.
  - pause_toggle → INGAME.
  - start_game → START, abandoning the round; rounds_played unchanged.
- WINGAME / LOSTGAME:
  - guess_valid and pause_toggle ignored.
  - On start_game: if rounds_played == NUM_ROUNDS → MATCHOVER; otherwise → START.
- MATCHOVER: hold. On start_game → START and clear rounds_won and rounds_played.
- Latency: state and counter updates are visible one cycle after the causing input.
- Unused encodings 6 and 7 recover to START on the next cycle.

Decomposition:
- Shared package game_pkg holds:
  - state localparams (START, INGAME, WINGAME, LOSTGAME, PAUSED, MATCHOVER);
  - the 3-bit state width;
  - default MAX_MISSES and NUM_ROUNDS.
- One natural sub-module, guess_timer: loadable down-counter with enable, reload and expiry output, parametrised by TIMEOUT_CYCLES and TMR_W.
- The FSM and round counters stay in the top module.

Test Plan:
- Reset/start: hold reset=0 for 2 cycles, release, pulse start_game with word_len=5 → state 0 then 1; miss_count=0, revealed_count=0.
- Win: word_len=5; valid hits with hit_count 2, 1, 2 → after the third guess state=2, revealed_count=5, rounds_won=1, rounds_played=1. Overshoot hit_count=3 with 4 already revealed → revealed_count saturates at 5.
- Loss: MAX_MISSES=6; 6 valid misses → state=3 the cycle after the 6th miss, miss_count=6, rounds_won unchanged.
- Timeout: TIMEOUT_CYCLES=10, no guesses → miss_count increments every 10 cycles. Pause after 4 cycles → guess_timer holds 6; resume → miss occurs 6 cycles later.
- Match: NUM_ROUNDS=3; win, lose, win → start_game after round 3 gives state=5 with rounds_won=2; next start_game → state 0 with both counters 0.
- Abort/priority: pause_toggle and a valid miss in the same cycle → miss counted, stays INGAME. Reset pulled low mid-round → state 0 and all counters 0 next cycle.
